frame_scheduler: RTL

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/frame_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/frame_scheduler.sv
// Paced multi-port frame scheduler: per-port interval timers mint credits, round-robin offer to one builder.
// Latency: start sampled at edge N -> sched_valid registered high after edge N+1; one offer per two cycles max.
// Backpressure: an offer is held stable until sched_ready; credits keep accruing up to MAX_CREDIT, excess ticks set overrun.
module frame_scheduler #(
  parameter int TEST_PORT_NUM = 4,
  parameter int MAX_CREDIT    = 4,
  parameter int PW            = $clog2(TEST_PORT_NUM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TEST_PORT_NUM-1:0]      start,
  input  logic [TEST_PORT_NUM-1:0]      stop,
  input  logic [TEST_PORT_NUM*32-1:0]   interval,
  output logic                          sched_valid,
  output logic [PW-1:0]                 sched_port,
  input  logic                          sched_ready,
  output logic [TEST_PORT_NUM*32-1:0]   frames_issued,
  output logic [TEST_PORT_NUM-1:0]      overrun,
  output logic                          busy
);

  localparam int CW = $clog2(MAX_CREDIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_CREDIT);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state  [TEST_PORT_NUM];
  logic [31:0]         cnt    [TEST_PORT_NUM];
  logic [CW-1:0]       credit [TEST_PORT_NUM];
  logic [31:0]         issued [TEST_PORT_NUM];
  logic [31:0]         lim    [TEST_PORT_NUM];
  logic [PW-1:0]       ptr;

  logic [TEST_PORT_NUM-1:0] tick;
  logic [TEST_PORT_NUM-1:0] acc;
  logic [TEST_PORT_NUM-1:0] elig;
  logic [TEST_PORT_NUM-1:0] running;
  logic                     found;
  logic [PW-1:0]            pick;
  int                       sel;

  // Per-port tick, acceptance and eligibility decode (interval 0 behaves as 1).
  always_comb begin
    for (int i = 0; i < TEST_PORT_NUM; i++) begin
      lim[i]     = (interval[32*i +: 32] == 32'd0) ? 32'd0 : interval[32*i +: 32] - 32'd1;
      running[i] = (state[i] == RUN);
      // >= rather than == so a live shrink of interval below the counter ticks at once instead of wrapping 2^32.
      tick[i]    = running[i] && (cnt[i] >= lim[i]);
      acc[i]     = sched_valid && sched_ready && (sched_port == PW'(i));
      // A port being stopped this cycle is not offered.
      elig[i]    = running[i] && (credit[i] != '0) && !stop[i];
    end
  end

  // Round-robin search: first eligible port at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sel   = 0;
    for (int k = 0; k < TEST_PORT_NUM; k++) begin
      sel = int'(ptr) + k;
      if (sel >= TEST_PORT_NUM) sel = sel - TEST_PORT_NUM;
      if (!found && elig[sel]) begin
        found = 1'b1;
        pick  = PW'(sel);
      end
    end
  end

  // Per-port run state, interval counter, credit, issued count and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TEST_PORT_NUM; i++) begin
        state[i]  <= IDLE;
        cnt[i]    <= 32'd0;
        credit[i] <= '0;
        issued[i] <= 32'd0;
        overrun[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < TEST_PORT_NUM; i++) begin
        // An offer already on the bus is always counted, even for a port stopped meanwhile.
        if (acc[i]) issued[i] <= issued[i] + 32'd1;
        if (stop[i]) begin
          state[i]  <= IDLE;
          credit[i] <= '0;
          cnt[i]    <= 32'd0;
        end else if (start[i] && (state[i] == IDLE)) begin
          state[i]   <= RUN;
          cnt[i]     <= 32'd0;
          credit[i]  <= CW'(1);
          overrun[i] <= 1'b0;
          issued[i]  <= acc[i] ? 32'd1 : 32'd0;
        end else if (state[i] == RUN) begin
          cnt[i] <= tick[i] ? 32'd0 : cnt[i] + 32'd1;
          // Tick and accept on the same port cancel: credit unchanged, no overrun.
          if (tick[i] && !acc[i]) begin
            if (credit[i] == CMAX) overrun[i] <= 1'b1;
            else                   credit[i]  <= credit[i] + CW'(1);
          end else if (!tick[i] && acc[i] && (credit[i] != '0)) begin
            credit[i] <= credit[i] - CW'(1);
          end
        end
      end
    end
  end

  // Offer register: hold while stalled, drop after accept, re-arbitrate only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sched_valid <= 1'b0;
      sched_port  <= '0;
      ptr         <= '0;
    end else if (sched_valid) begin
      if (sched_ready) begin
        sched_valid <= 1'b0;
        ptr <= (sched_port == PW'(TEST_PORT_NUM - 1)) ? '0 : sched_port + PW'(1);
      end
    end else if (found) begin
      sched_valid <= 1'b1;
      sched_port  <= pick;
    end
  end

  // Flatten issued counts onto the output bus.
  always_comb begin
    frames_issued = '0;
    for (int i = 0; i < TEST_PORT_NUM; i++) frames_issued[32*i +: 32] = issued[i];
  end

  assign busy = (|running) || sched_valid;

endmodule
